// File: rtl/niospherisys_cpu_ocimem_arbiter_if.sv
// Bundle of JTAG command, Avalon debug slave, OCI RAM and monitor signals around the OCI RAM arbiter.
// slave = arbiter side, master = surrounding debug core / RAM.
interface niospherisys_cpu_ocimem_arbiter_if #(
    parameter int unsigned RAM_AW = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic              debugack;

    logic [RAM_AW-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic              av_debugaccess;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    logic [RAM_AW-1:0] ram_addr;
    logic              ram_wr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata;

    logic [31:0]       MonDReg;
    logic [RAM_AW-1:0] MonAReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, debugack,
        input  av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        output av_readdata, av_waitrequest,
        output ram_addr, ram_wr, ram_wdata, ram_be,
        input  ram_rdata,
        output MonDReg, MonAReg, monitor_ready, monitor_error
    );

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, debugack,
        output av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        input  av_readdata, av_waitrequest,
        input  ram_addr, ram_wr, ram_wdata, ram_be,
        output ram_rdata,
        input  MonDReg, MonAReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/niospherisys_cpu_ocimem_arbiter.sv
// Single-port OCI RAM arbiter: alternating-priority sharing between the Avalon debug slave and JTAG commands.
// Optional macro OCIMEM_AUTOINC_EN: MonAReg post-increments after every completed JTAG access.
module niospherisys_cpu_ocimem_arbiter #(
    parameter int unsigned       RAM_AW    = 8,
    parameter logic [RAM_AW-1:0] PROT_BASE = RAM_AW'(8'h80)
) (
    input  logic clk,
    input  logic reset_n,
    niospherisys_cpu_ocimem_arbiter_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

`ifdef OCIMEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AV_RD = 2'd1,
        ST_JT_RD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              jt_pend_q, jt_pend_d;
    logic              jt_wr_q, jt_wr_d;
    logic              last_jtag_q, last_jtag_d;
    logic [DW-1:0]     mon_d_q, mon_d_d;
    logic [RAM_AW-1:0] mon_a_q, mon_a_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic idle, av_req, jt_req, grant_av, grant_jt;
    logic av_prot, jt_prot, av_done, jt_done, jt_err;
    logic post_wr, post_rd, post_any;
    logic unused_jdo;

    assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

    // Grant decode; requests are masked while reset is asserted so nothing reaches the RAM
    always_comb begin
        idle     = (state_q == ST_IDLE);
        av_req   = reset_n & (bus.av_read | bus.av_write);
        jt_req   = reset_n & jt_pend_q;
        grant_av = idle & av_req & (~jt_req | last_jtag_q);
        grant_jt = idle & jt_req & (~av_req | ~last_jtag_q);
        av_prot  = (bus.av_address >= PROT_BASE) & ~bus.av_debugaccess;
        jt_prot  = (mon_a_q >= PROT_BASE) & ~bus.debugack;
        av_done  = (grant_av & bus.av_write) | (state_q == ST_AV_RD);
        jt_err   = grant_jt & jt_prot;
        jt_done  = (grant_jt & (jt_wr_q | jt_prot)) | (state_q == ST_JT_RD);
        post_wr  = bus.take_action_ocimem_b;
        post_rd  = bus.take_no_action_ocimem_a | (bus.take_action_ocimem_a & bus.jdo[35]);
        post_any = post_wr | post_rd;
    end

    assign bus.ram_addr       = grant_av ? bus.av_address : mon_a_q;
    assign bus.ram_wdata      = grant_av ? bus.av_writedata : mon_d_q;
    assign bus.ram_be         = grant_av ? bus.av_byteenable : {BW{1'b1}};
    assign bus.ram_wr         = (grant_av & bus.av_write & ~av_prot) | (grant_jt & jt_wr_q & ~jt_prot);
    assign bus.av_readdata    = (state_q == ST_AV_RD) ? bus.ram_rdata : '0;
    assign bus.av_waitrequest = (bus.av_read | bus.av_write) & ~av_done;
    assign bus.MonDReg        = mon_d_q;
    assign bus.MonAReg        = mon_a_q;
    assign bus.monitor_ready  = ready_q;
    assign bus.monitor_error  = error_q;

    // Next-state for FSM, JTAG request register and monitor registers
    always_comb begin
        state_d     = ST_IDLE;
        jt_pend_d   = jt_pend_q;
        jt_wr_d     = jt_wr_q;
        last_jtag_d = last_jtag_q;
        mon_d_d     = mon_d_q;
        mon_a_d     = mon_a_q;
        ready_d     = ready_q;
        error_d     = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_av && !bus.av_write) begin
                    state_d = ST_AV_RD;
                end else if (grant_jt && !jt_wr_q && !jt_prot) begin
                    state_d = ST_JT_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_jt) begin
            last_jtag_d = 1'b1;
        end else if (grant_av) begin
            last_jtag_d = 1'b0;
        end

        // A new post supersedes whatever is pending, even one granted this cycle
        if (post_any) begin
            jt_pend_d = 1'b1;
            jt_wr_d   = post_wr;
        end else if (grant_jt) begin
            jt_pend_d = 1'b0;
        end

        if (state_q == ST_JT_RD) begin
            mon_d_d = bus.ram_rdata;
        end
        if (post_wr) begin
            mon_d_d = bus.jdo[34:3];
        end

        if (bus.take_action_ocimem_a) begin
            mon_a_d = RAM_AW'(bus.jdo[33:26]);
        end else if (AUTOINC && jt_done) begin
            mon_a_d = mon_a_q + RAM_AW'(1);
        end

        if (bus.take_action_ocimem_a) begin
            ready_d = 1'b0;
        end else if (jt_done) begin
            ready_d = 1'b1;
        end

        if (bus.take_action_ocimem_a) begin
            error_d = 1'b0;
        end
        if (jt_err || (jt_pend_q && (bus.take_action_ocimem_b || bus.take_no_action_ocimem_a))) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            jt_pend_q   <= 1'b0;
            jt_wr_q     <= 1'b0;
            last_jtag_q <= 1'b0;
            mon_d_q     <= '0;
            mon_a_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            jt_pend_q   <= jt_pend_d;
            jt_wr_q     <= jt_wr_d;
            last_jtag_q <= last_jtag_d;
            mon_d_q     <= mon_d_d;
            mon_a_q     <= mon_a_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: doc/niospherisys_cpu_ocimem_arbiter.md
# niospherisys_cpu_ocimem_arbiter

Arbitrates the single-port on-chip debug memory (OCI RAM) between two requesters: the CPU-side Avalon debug slave and the JTAG debug path's sysclk-domain command strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`, `jdo`). It sequences each JTAG memory command into a RAM cycle, returns read data in `MonDReg`, and reports completion through `monitor_ready` and faults through `monitor_error`. It sits in the CPU's debug core, between the JTAG debug module wrapper and the OCI RAM instance.

## Interface
- `RAM_AW`, default 8: OCI RAM word-address width.
- `PROT_BASE`, default 8'h80: first word address of the protected region.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `jdo` in 38: JTAG command/data word, valid with the strobes.
- `take_action_ocimem_a` in 1: load command. `jdo[35]` = read, `jdo[34]` = write, `jdo[33:26]` = word address.
- `take_action_ocimem_b` in 1: load write data `jdo[34:3]` and post the write.
- `take_no_action_ocimem_a` in 1: post a read at the current address.
- `debugack` in 1: CPU is in debug mode.
- `av_address` in RAM_AW: Avalon word address.
- `av_read` in 1: Avalon read request.
- `av_write` in 1: Avalon write request.
- `av_writedata` in 32: Avalon write data.
- `av_byteenable` in 4: Avalon byte enables.
- `av_debugaccess` in 1: access is privileged.
- `av_readdata` out 32: read data.
- `av_waitrequest` out 1: Avalon stall.
- `ram_addr` out RAM_AW: RAM address.
- `ram_wr` out 1: RAM write enable.
- `ram_wdata` out 32: RAM write data.
- `ram_be` out 4: RAM byte enables.
- `ram_rdata` in 32: RAM read data; registered, valid 1 cycle after address.
- `MonDReg` out 32: JTAG data register.
- `MonAReg` out RAM_AW: JTAG address register.
- `monitor_ready` out 1: last JTAG access has completed.
- `monitor_error` out 1: sticky JTAG fault flag.

## Operation
- JTAG request register holds `jt_pend` and `jt_wr`.
  - Strobe b sets pend with wr=1.
  - Strobe no_action_a sets pend with wr=0.
  - Strobe a loads `MonAReg`, clears `monitor_ready` and `monitor_error`, and posts a read if `jdo[35]`.
- FSM states:
  - IDLE: arbitrate.
  - AV_RD: return Avalon data.
  - JT_RD: capture into `MonDReg`.
- Arbitration in IDLE, one grant per cycle.
  - If only one requester is pending, it wins.
  - If both are pending, the requester not granted last wins (alternating priority). `last_jtag` resets to 0, so JTAG wins the first tie.
- Avalon write grant: RAM write that cycle; `av_waitrequest` is low that cycle. Stay in IDLE.
- Avalon read grant: RAM read; go to AV_RD. In AV_RD, `av_readdata` = `ram_rdata`, `av_waitrequest` = 0; return to IDLE.
- JTAG write grant: write `MonDReg` to `MonAReg` with all byte enables. Clear pend and set `monitor_ready`.
- JTAG read grant: go to JT_RD. In JT_RD, `MonDReg` <= `ram_rdata`, set `monitor_ready`, return to IDLE.
- Protection:
  - Avalon write to an address >= PROT_BASE with `av_debugaccess`=0 completes but `ram_wr` = 0.
  - JTAG access to an address >= PROT_BASE with `debugack`=0 does not touch RAM. It sets `monitor_error` and `monitor_ready`; `MonDReg` is unchanged.
- A new post (b or no_action_a) while `jt_pend`=1 sets `monitor_error`; the latest request replaces the pending one.
- `av_waitrequest` = (`av_read` | `av_write`) & ~completing-this-cycle.

## Timing
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=0, `monitor_error`=0, `av_readdata`=0, `ram_wr`=0, state IDLE, `jt_pend`=0.
- Avalon latency with no contention: write 1 cycle; read 2 cycles (data valid in cycle 2).
- JTAG latency with no contention: write completes 1 cycle after the post; read has `MonDReg` valid and `monitor_ready` set 2 cycles after the post.
- Worst-case wait behind the other requester: 2 cycles.
- Strobe a and a post in the same cycle: the address loads first; the post uses the new address.
- Reset asserted mid-transaction: the access is abandoned, FSM returns to IDLE, no RAM write completes after reset assertion.

## Configuration
- `OCIMEM_AUTOINC_EN`:
  - Defined: `MonAReg` increments by 1 after every completed JTAG access (including protected/errored ones), wrapping 2^RAM_AW-1 -> 0.
  - Undefined: `MonAReg` changes only on `take_action_ocimem_a`.

## Test plan
- JTAG write: a (addr 0x10, debugack=1), then b with data 0xDEADBEEF -> one `ram_wr` at 0x10 next cycle, `monitor_ready`=1. A read then gives `MonDReg`=0xDEADBEEF.
- Simultaneous Avalon read of 0x20 and a JTAG read post from reset -> JTAG granted first, Avalon granted next. `av_waitrequest` is high for 3 cycles, then data valid.
- Avalon write to 0x90 with `av_debugaccess`=0 -> `av_waitrequest` low, no `ram_wr`. The same write with `av_debugaccess`=1 -> `ram_wr`=1.
- JTAG read of 0x85 with `debugack`=0 -> `monitor_error`=1, `monitor_ready`=1, `MonDReg` unchanged, no RAM access.
- With `OCIMEM_AUTOINC_EN`: address 0xFF, two JTAG reads -> accesses at 0xFF then 0x00. Without the macro -> both at 0xFF.
- `reset_n` pulsed low during AV_RD -> all outputs return to reset values and the next Avalon read completes normally.
